// File: rtl/reg9_write_arbiter_if.sv
// Requester-side bundle for the shared 9-bit register write arbiter.
interface reg9_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         writeData;
  logic                      writeReg;
  logic                      busy;

  // Requesters drive req/req_data and observe the arbiter outputs.
  modport master (
    output req, req_data,
    input  grant, ack, writeData, writeReg, busy
  );

  // The arbiter samples requests and drives grant/ack and the register port.
  modport slave (
    input  req, req_data,
    output grant, ack, writeData, writeReg, busy
  );
endinterface

// File: rtl/reg9_write_arbiter.sv
// Round-robin write arbiter for a shared register: IDLE picks a winner,
// WRITE pulses writeReg, ACK pulses the winner's ack, then back to IDLE.
module reg9_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  reg9_write_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wreg_q, wreg_d;
  logic               busy_q, busy_d;

  // Per-requester view of the flat data bus so the winner can be muxed by index.
  logic [DATA_W-1:0]  rd [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rd
    assign rd[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Next-state and output logic; the rotating scan starts just past last winner.
  always_comb begin : arb_comb
    int               idx;
    logic             found;
    logic [PTR_W-1:0] sel;
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    busy_d  = busy_q;
    idx     = 0;
    found   = 1'b0;
    sel     = '0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = int'(last_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          sel = PTR_W'(idx);
          if (!found && bus.req[sel]) begin
            found        = 1'b1;
            grant_d      = '0;
            grant_d[sel] = 1'b1;
            wdata_d      = rd[sel];
            last_d       = sel;
            wreg_d       = 1'b1;
            busy_d       = 1'b1;
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // Write is committed once writeReg has been high; no abort path.
        wreg_d  = 1'b0;
        ack_d   = grant_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ack_d   = '0;
        grant_d = '0;
        wreg_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset puts requester 0 first in line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.writeData = wdata_q;
  assign bus.writeReg  = wreg_q;
  assign bus.busy      = busy_q;
endmodule
